// File: rtl/negedge_serial_tx.sv
// negedge_serial_tx: falling-edge frame transmitter, LSB first, framed by start and stop bits.
// Define NEGEDGE_SERIAL_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module negedge_serial_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_line,
    output logic              busy
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BaudW-1:0] LastBaud = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_W - 1);

`ifdef NEGEDGE_SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, shift_nxt;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic              line_q, line_d;
    logic              busy_q;
    logic              baud_end;

`ifdef NEGEDGE_SERIAL_TX_PARITY_EN
    logic parity_q, parity_d;
`endif

    assign tx_ready = (state_q == StIdle);
    assign tx_line  = line_q;
    assign busy     = busy_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        baud_d    = baud_q;
        line_d    = line_q;
        baud_end  = (baud_q == LastBaud);
        shift_nxt = shift_q >> 1;
`ifdef NEGEDGE_SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        // Outside IDLE the baud counter free-runs and wraps at each bit boundary.
        if (state_q != StIdle) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                line_d = 1'b1;
                if (tx_valid) begin
                    state_d   = StStart;
                    shift_d   = tx_data;
                    bit_cnt_d = '0;
                    baud_d    = '0;
                    line_d    = 1'b0;
`ifdef NEGEDGE_SERIAL_TX_PARITY_EN
                    parity_d  = ^tx_data;
`endif
                end
            end
            StStart: begin
                if (baud_end) begin
                    state_d = StData;
                    line_d  = shift_q[0];
                end
            end
            StData: begin
                if (baud_end) begin
                    shift_d   = shift_nxt;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
`ifdef NEGEDGE_SERIAL_TX_PARITY_EN
                        state_d   = StParity;
                        line_d    = parity_q;
`else
                        state_d   = StStop;
                        line_d    = 1'b1;
`endif
                    end else begin
                        line_d = shift_nxt[0];
                    end
                end
            end
`ifdef NEGEDGE_SERIAL_TX_PARITY_EN
            StParity: begin
                if (baud_end) begin
                    state_d = StStop;
                    line_d  = 1'b1;
                end
            end
`endif
            StStop: begin
                // Returning to IDLE never accepts in the same edge: guarantees a one-clock gap.
                if (baud_end) begin
                    state_d = StIdle;
                    line_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                line_d  = 1'b1;
                baud_d  = '0;
            end
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            baud_q    <= '0;
            line_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            baud_q    <= baud_d;
            line_q    <= line_d;
            busy_q    <= (state_d != StIdle);
        end
    end

`ifdef NEGEDGE_SERIAL_TX_PARITY_EN
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_negedge_serial_tx.sv
// Scoreboard bench for negedge_serial_tx: a frame-level model predicts accept edges and line
// waveforms; a monitor compares every clock against the oldest predicted frame.
`timescale 1ns/1ps
module tb_negedge_serial_tx;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CPB    = 4;
`ifdef NEGEDGE_SERIAL_TX_PARITY_EN
    localparam int unsigned NBITS  = DATA_W + 3;
`else
    localparam int unsigned NBITS  = DATA_W + 2;
`endif
    localparam int unsigned FRAME_CLKS = NBITS * CPB;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic              tx_line;
    logic              busy;

    negedge_serial_tx #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_line  (tx_line),
        .busy     (busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] word;
        int                start;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   model_free = 0;
    int   checks = 0;
    int   errors = 0;
    bit   in_frame = 1'b0;

    always @(negedge clk) cyc <= cyc + 1;

    // Line value of bit slot b of a frame carrying w: start, data LSB first, [parity], stop.
    function automatic logic frame_bit(input logic [DATA_W-1:0] w, input int unsigned b);
        if (b == 0) return 1'b0;
        if (b <= DATA_W) return w[b-1];
`ifdef NEGEDGE_SERIAL_TX_PARITY_EN
        if (b == DATA_W + 1) return ^w;
`endif
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus; the model decides whether this falling edge accepts.
    task automatic step(input logic v, input logic [DATA_W-1:0] d);
        int k;
        @(posedge clk);
        #1;
        tx_valid = v;
        tx_data  = d;
        @(negedge clk);
        k = cyc;
        if (v && !rst && k >= model_free) begin
            exp_q.push_back('{word: d, start: k});
            model_free = k + FRAME_CLKS + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, DATA_W'($urandom));
    endtask

    task automatic send(input logic [DATA_W-1:0] w);
        step(1'b1, w);
        idle(FRAME_CLKS + 2);
    endtask

    // Assert rst between edges and check that outputs respond with no clock edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        rst = 1'b1;
        #1;
        exp_q.delete();
        model_free = 0;
        check("rst_line", tx_line, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", tx_ready, 1'b1);
        repeat (3) begin
            @(negedge clk);
            #2;
            check("rst_hold_line", tx_line, 1'b1);
            check("rst_hold_busy", busy, 1'b0);
            check("rst_hold_ready", tx_ready, 1'b1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : monitor
        int   k;
        int   idx;
        exp_t cur;
        logic exp_line;
        logic exp_busy;
        idx = 0;
        forever begin
            @(negedge clk);
            k = cyc;
            #1;
            if (rst) begin
                in_frame = 1'b0;
                continue;
            end
            if (!in_frame && exp_q.size() > 0 && exp_q[0].start == k) begin
                cur = exp_q.pop_front();
                in_frame = 1'b1;
                idx = 0;
            end
            if (in_frame) begin
                exp_line = frame_bit(cur.word, idx / CPB);
                exp_busy = 1'b1;
            end else begin
                exp_line = 1'b1;
                exp_busy = 1'b0;
            end
            check("tx_line", tx_line, exp_line);
            check("busy", busy, exp_busy);
            check("tx_ready", tx_ready, !exp_busy);
            if (in_frame) begin
                idx++;
                if (idx == FRAME_CLKS) in_frame = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int guard;
        do_reset();
        idle(2);

        send(8'hA5);

        // Pulse while busy must be dropped.
        step(1'b1, 8'h3C);
        idle(10);
        step(1'b1, 8'hFF);
        idle(FRAME_CLKS);

        // Valid held high: 0x01 then 0x80 back-to-back.
        step(1'b1, 8'h01);
        repeat (FRAME_CLKS + 1) step(1'b1, 8'h80);
        idle(FRAME_CLKS + 2);

        send(8'h07);
        send(8'h00);

        // Reset during data bit 3.
        step(1'b1, 8'hC3);
        idle(4 * CPB + 1);
        do_reset();
        idle(20);
        send(8'h55);

        // Random valid/data with data changing every clock.
        repeat (1500) step(($urandom_range(0, 3) == 0), DATA_W'($urandom));
        repeat (300) step(1'b1, DATA_W'($urandom));

        guard = 0;
        while ((exp_q.size() != 0 || in_frame) && guard < 1000) begin
            step(1'b0, '0);
            guard++;
        end
        checks++;
        if (guard >= 1000) begin
            errors++;
            $display("FAIL drain_timeout: %0d frames still pending, expected 0", exp_q.size());
        end
        idle(FRAME_CLKS);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/negedge_serial_tx.md
Name: negedge_serial_tx

Overview:
Parallel-in, serial-out frame transmitter. It is the transmit end of the team's serial link, whose receive side samples the line with falling-edge flip-flops.
- All state updates on the falling edge of clk, so launch and capture edges match the receiver's flop style.
- Accepts one DATA_W word per valid/ready handshake and shifts it out LSB first, framed by a start bit and a stop bit.

Parameters:
DATA_W, 8, payload bits per frame (min 1)
CLKS_PER_BIT, 4, clk periods each line bit is held (min 1)

Ports:
clk  input  1  clock; all sequential updates on the falling edge
rst  input  1  reset, asynchronous, active-high
tx_data  input  DATA_W  word to send; sampled only at the accepting edge
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a word; combinational, high exactly when state is IDLE
tx_line  output  1  serial line, registered; idles high
busy  output  1  frame in progress; registered; equals NOT tx_ready

Behaviour:
- Reset (rst=1), applied immediately without waiting for a clock edge:
  - state=IDLE, tx_line=1, busy=0, tx_ready=1
  - shift register cleared, bit counter 0, baud counter 0
- Reset mid-frame: line returns high at once; the frame is discarded and never resumed. After rst falls, the first possible accept is the next falling edge.
- States: IDLE, START, DATA, (PARITY, only with the optional feature), STOP.
- IDLE:
  - tx_line=1.
  - Falling edge with tx_valid=1 accepts the word: latch tx_data, go to START, drive tx_line=0 at that same edge, baud counter=0.
  - tx_valid=0: stay in IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT), minimum 1 bit.
  - Increments each falling edge. Each bit is held exactly CLKS_PER_BIT edges; on the edge where the count reaches CLKS_PER_BIT-1, the counter wraps to 0 and the next bit is driven.
- START → DATA:
  - tx_line=shift[0].
  - Each DATA bit period end: shift right, bit counter +1.
  - After bit DATA_W-1 → STOP (or PARITY when enabled).
- STOP:
  - tx_line=1 for CLKS_PER_BIT edges, then IDLE.
  - No accept is possible in the STOP-to-IDLE transition edge. Minimum gap between frames is one clk period with the line high in IDLE.
- Frame length: (DATA_W+2)*CLKS_PER_BIT clocks, or (DATA_W+3)*CLKS_PER_BIT with parity.
- Handshake rules:
  - tx_valid while busy is ignored; no queueing.
  - tx_data changes after the accept do not affect the frame in flight.
  - tx_valid may be held high continuously; frames then issue back-to-back with the 1-clock idle gap.
- CLKS_PER_BIT=1: every bit lasts one clk period; counter logic degenerates without error.

Optional Feature:
Macro: NEGEDGE_SERIAL_TX_PARITY_EN
- Defined:
  - PARITY state inserted between DATA and STOP.
  - tx_line = even parity of the latched word (XOR of all DATA_W bits), held CLKS_PER_BIT edges.
  - Parity is computed at accept time from tx_data, not from the shifting register.
- Not defined: PARITY state and parity logic are absent; DATA goes directly to STOP.

Test Plan:
- Reset check: assert rst between clk edges → tx_line=1, busy=0, tx_ready=1 immediately, with no clock edge. Hold for 3 clocks → outputs unchanged.
- Basic frame, DATA_W=8, CLKS_PER_BIT=4, send 0xA5 → line sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 clocks, 40 clocks total. Line is 1 and tx_ready=1 on the following edge.
- Busy ignore: send 0x3C, pulse tx_valid with 0xFF mid-frame → only 0x3C is transmitted; no second frame starts.
- Back-to-back: tx_valid held high with 0x01 then 0x80 → two correct frames separated by exactly 1 clk of line high.
- Reset mid-frame: assert rst during the DATA bit 3 period → line=1 at once; after release with tx_valid=0 the line stays high. A new 0x55 sends a complete, correct frame.
- Parity (macro defined):
  - 0x07 → parity bit 1, frame 44 clocks.
  - 0x00 → line low for 9 bit periods (start plus 8 data bits) and parity 0, i.e. 10 consecutive low bit periods, then stop high.
